// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer.
// Runs fetch/decode/execute/memory/writeback over one shared memory port,
// counts retired instructions and halts sticky on illegal opcode or memory timeout.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for Run at an instruction boundary
//   FETCH  | instruction read from memory at PC, IR loads on MemReady
//   DECODE | opcode legality check
//   EXEC   | ALU cycle; branches retire here
//   MEM    | data access at ALU result; stores retire here
//   WB     | register-file write, retire
//   HALT   | sticky fault, left only through reset
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Run,
    input  logic [6:0]       OpCode,
    input  logic             RUWrDec,
    input  logic             DMWrDec,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             MemWe,
    output logic             MemAddrSrc,
    output logic             IRWr,
    output logic             PCWr,
    output logic             RUWrEn,
    output logic [2:0]       State,
    output logic             Fault,
    output logic [CNT_W-1:0] InstRetired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Timer must hold MEM_TIMEOUT itself: it increments once more on the expiring cycle.
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [2:0]       next_boundary;
    logic [TW-1:0]    wait_q;
    logic             fault_q;
    logic [CNT_W-1:0] cnt_q;
    logic             legal;
    logic             is_load;
    logic             is_mem_op;
    logic             timed_out;

    assign State       = state_q;
    assign Fault       = fault_q;
    assign InstRetired = cnt_q;

    // Opcode classification from the instruction register bits.
    always_comb begin
        legal = 1'b0;
        case (OpCode)
            OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BR,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
    end

    assign is_load       = (OpCode == OP_LOAD);
    assign is_mem_op     = is_load || (OpCode == OP_STORE);
    assign next_boundary = Run ? S_FETCH : S_IDLE;
    assign timed_out     = MemReq && !MemReady && (wait_q == TW'(MEM_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Run only matters where an instruction boundary is reached.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (Run) state_d = S_FETCH;
            S_FETCH: begin
                if (MemReady)       state_d = S_DECODE;
                else if (timed_out) state_d = S_HALT;
            end
            S_DECODE: state_d = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (is_mem_op)    state_d = S_MEM;
                else if (RUWrDec) state_d = S_WB;
                else              state_d = next_boundary;
            end
            S_MEM: begin
                if (MemReady)       state_d = is_load ? S_WB : next_boundary;
                else if (timed_out) state_d = S_HALT;
            end
            S_WB:     state_d = next_boundary;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode; request signals depend on state only so they hold until MemReady.
    always_comb begin
        MemReq     = 1'b0;
        MemWe      = 1'b0;
        MemAddrSrc = 1'b0;
        IRWr       = 1'b0;
        PCWr       = 1'b0;
        RUWrEn     = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemReq = 1'b1;
                IRWr   = MemReady;
            end
            S_EXEC:  PCWr = !is_mem_op && !RUWrDec;
            S_MEM: begin
                MemReq     = 1'b1;
                MemAddrSrc = 1'b1;
                MemWe      = DMWrDec;
                PCWr       = MemReady && !is_load;
            end
            S_WB: begin
                RUWrEn = 1'b1;
                PCWr   = 1'b1;
            end
            default: ;
        endcase
    end

    // Memory wait timer: cleared on entry to a request state, counts unanswered cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) begin
            wait_q <= '0;
        end else if (MemReq && !MemReady) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    // Sticky fault, set on any transition into HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (state_d == S_HALT) begin
            fault_q <= 1'b1;
        end
    end

    // Retired-instruction counter; every PC update is one retirement, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (PCWr) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
